// File: rtl/cdc_hs_tx_arbiter.sv
// Clock-A side of a 4-phase req/ack multi-bit CDC channel: round-robin arbiter over N_SRC requesters.
// Optional ack-wait timeout is compiled in when CDC_HS_TIMEOUT_EN is defined.
module cdc_hs_tx_arbiter #(
   parameter int N_SRC       = 4,
   parameter int DATA_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_SRC-1:0]         i_src_valid,
   input  logic [N_SRC*DATA_W-1:0]  i_src_data,
   output logic [N_SRC-1:0]         o_src_ready,
   input  logic                     i_data_ack,
   output logic                     o_data_req,
   output logic [DATA_W-1:0]        o_data,
   output logic [$clog2(N_SRC)-1:0] o_grant_id,
   output logic                     o_busy,
   output logic                     o_timeout
);
   localparam int ID_W = $clog2(N_SRC);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT_LO = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic                   w_ack_s;
   logic [ID_W-1:0]        r_ptr;
   logic [ID_W-1:0]        w_pick;
   logic [ID_W-1:0]        w_ptr_next;
   logic [ID_W:0]          w_idx;
   logic                   w_found;
   logic                   w_accept;
   logic                   w_timeout_hit;
   logic                   r_data_req;
   logic [DATA_W-1:0]      r_data;
   logic [ID_W-1:0]        r_grant_id;
   logic [DATA_W-1:0]      w_src_word [N_SRC];

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_word
         assign w_src_word[gi] = i_src_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Only the synchronized ack is ever looked at; the raw input is asynchronous.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ack_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_data_ack};
      end
   end
   assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

   // First valid requester at or after the pointer, scanning with wrap-around.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(N_SRC)) begin
            w_idx = w_idx - (ID_W+1)'(N_SRC);
         end
         if (!w_found && i_src_valid[w_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[ID_W-1:0];
         end
      end
   end

   assign w_ptr_next = (w_pick == ID_W'(N_SRC-1)) ? '0 : w_pick + 1'b1;
   assign w_accept   = (r_state == ST_IDLE) && w_found;

`ifdef CDC_HS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC+1);

   logic [CNT_W-1:0] r_to_cnt;
   logic             r_timeout;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeout_hit;
         if (w_accept) begin
            r_to_cnt <= '0;
         end else if (r_state == ST_REQ) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end
   end

   // Fires on the last of TIMEOUT_CYC request cycles, so req is seen high exactly that long.
   assign w_timeout_hit = (r_state == ST_REQ) && !w_ack_s && (r_to_cnt == CNT_W'(TIMEOUT_CYC-1));
   assign o_timeout     = r_timeout;
`else
   // Without the timeout the request waits for ack indefinitely; this term is always false.
   assign w_timeout_hit = (TIMEOUT_CYC < 0);
   assign o_timeout     = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_found)                      w_state_next = ST_REQ;
         ST_REQ:     if (w_ack_s || w_timeout_hit)     w_state_next = ST_WAIT_LO;
         ST_WAIT_LO: if (!w_ack_s)                     w_state_next = ST_IDLE;
         default:                                      w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_data_req <= 1'b0;
         r_data     <= '0;
         r_grant_id <= '0;
         r_ptr      <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_data     <= w_src_word[w_pick];
            r_grant_id <= w_pick;
            r_ptr      <= w_ptr_next;
            r_data_req <= 1'b1;
         end else if ((r_state == ST_REQ) && (w_ack_s || w_timeout_hit)) begin
            r_data_req <= 1'b0;
         end
      end
   end

   always_comb begin
      o_src_ready = '0;
      if (i_rst_n && (r_state == ST_IDLE) && w_found) begin
         o_src_ready[w_pick] = 1'b1;
      end
      o_busy = (r_state != ST_IDLE);
   end

   assign o_data_req = r_data_req;
   assign o_data     = r_data;
   assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_cdc_hs_tx_arbiter.sv
// Bench for cdc_hs_tx_arbiter: clock-B receiver model, vector table, directed corner cases
// and a randomized run scored against a round-robin reference model.
`timescale 1ns/1ps
module tb_cdc_hs_tx_arbiter;
   localparam int N  = 4;
   localparam int W  = 4;
   localparam int SS = 2;
   localparam int TO = 8;

   logic        clk       = 1'b0;
   logic        clk_b     = 1'b0;
   logic        rst_n     = 1'b0;
   logic [3:0]  valid     = '0;
   logic [15:0] src_data  = '0;
   logic        ack_block = 1'b0;
   logic [3:0]  ready;
   logic        ack;
   logic        req;
   logic [3:0]  data;
   logic [1:0]  gid;
   logic        busy;
   logic        tmo;

   logic [1:0]  rx_sync;
   logic        rx_ack;
   logic [3:0]  rx_q[$];
   logic [3:0]  exp_q[$];

   int  checks = 0;
   int  errors = 0;
   time t_ack_rise = 0;
   time t_req_fall = 0;

   typedef struct {
      int          prime;
      logic [3:0]  valid;
      logic [15:0] data;
      logic [3:0]  exp_ready;
      logic [1:0]  exp_gid;
      logic [3:0]  exp_data;
   } vec_t;
   vec_t tbl[9];

   always #5 clk = ~clk;
   always #7 clk_b = ~clk_b;

   assign ack = rx_ack & ~ack_block;

   cdc_hs_tx_arbiter #(
      .N_SRC(N), .DATA_W(W), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_src_valid(valid), .i_src_data(src_data),
      .o_src_ready(ready), .i_data_ack(ack), .o_data_req(req), .o_data(data),
      .o_grant_id(gid), .o_busy(busy), .o_timeout(tmo)
   );

   // Receiver: 2-flop req synchronizer, ack follows the synced req, word captured on the rise.
   always @(posedge clk_b) begin
      if (!rst_n) begin
         rx_sync <= 2'b00;
         rx_ack  <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[0], req};
         rx_ack  <= rx_sync[1];
         if (rx_sync[1] && !rx_ack) rx_q.push_back(data);
      end
   end

   always @(posedge ack) t_ack_rise = $time;
   always @(negedge req) t_req_fall = $time;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      valid = '0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rx_q.delete();
   endtask

   task automatic xfer(input int src, input logic [3:0] word);
      @(posedge clk); #1;
      valid = '0;
      valid[src] = 1'b1;
      src_data[src*4 +: 4] = word;
      @(posedge clk); #1;
      valid = '0;
      wait_idle("xfer_idle");
   endtask

   // Reference arbitration: first valid at or after p, wrapping modulo N.
   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   int         n;
   int         bad_ready;
   int         bad_data;
   int         saw_tmo;
   int         g;
   int         m_ptr;
   int         m_g;
   bit         pending;
   logic [3:0] m_word;

   initial begin
      // prime = source transferred beforehand to move the pointer to prime+1 (-1: none)
      tbl[0] = '{-1, 4'b1111, 16'hD95C, 4'b0001, 2'd0, 4'hC};
      tbl[1] = '{-1, 4'b0110, 16'hD95C, 4'b0010, 2'd1, 4'h5};
      tbl[2] = '{ 0, 4'b1001, 16'hD95C, 4'b1000, 2'd3, 4'hD};
      tbl[3] = '{ 1, 4'b0011, 16'hD95C, 4'b0001, 2'd0, 4'hC};
      tbl[4] = '{ 3, 4'b1000, 16'hD95C, 4'b1000, 2'd3, 4'hD};
      tbl[5] = '{ 2, 4'b0111, 16'hD95C, 4'b0001, 2'd0, 4'hC};
      tbl[6] = '{ 2, 4'b1100, 16'hD95C, 4'b1000, 2'd3, 4'hD};
      tbl[7] = '{-1, 4'b0000, 16'hD95C, 4'b0000, 2'd0, 4'h0};
      tbl[8] = '{ 1, 4'b0110, 16'hD95C, 4'b0100, 2'd2, 4'h9};

      // Reset with every requester valid.
      rst_n = 1'b0;
      valid = 4'b1111;
      src_data = 16'hFFFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gid", 32'(gid), 32'd0);
      chk("rst_timeout", 32'(tmo), 32'd0);

      for (int i = 0; i < 9; i++) begin
         do_reset();
         if (tbl[i].prime >= 0) xfer(tbl[i].prime, 4'h0);
         @(posedge clk); #1;
         valid = tbl[i].valid;
         src_data = tbl[i].data;
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
         @(posedge clk); #1;
         valid = '0;
         if (tbl[i].exp_ready != 4'b0000) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), 32'(req), 32'd1);
            chk($sformatf("tbl%0d_gid", i), 32'(gid), 32'(tbl[i].exp_gid));
            chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].exp_data));
            wait_idle($sformatf("tbl%0d_idle", i));
         end else begin
            @(negedge clk);
            chk($sformatf("tbl%0d_no_req", i), 32'(req), 32'd0);
         end
      end

      // Single transfer from source 2.
      do_reset();
      @(posedge clk); #1;
      valid = 4'b0100;
      src_data = 16'h7A31;
      @(negedge clk);
      chk("single_ready", 32'(ready), 32'b0100);
      @(posedge clk); #1;
      valid = '0;
      @(negedge clk);
      chk("single_req", 32'(req), 32'd1);
      chk("single_data", 32'(data), 32'hA);
      chk("single_gid", 32'(gid), 32'd2);
      chk("single_busy", 32'(busy), 32'd1);
      chk("single_ready_off", 32'(ready), 32'd0);
      n = 0;
      while (req && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("single_req_fall", 32'(req), 32'd0);
      // SYNC_STAGES edges carry ack to ack_s, one more edge registers req low.
      chk("single_req_fall_edges",
          32'((t_req_fall - 5) / 10 - (t_ack_rise - 5) / 10), 32'(SS + 1));
      wait_idle("single_idle");
      chk("single_ack_low_at_idle", 32'(ack), 32'd0);
      chk("single_rx_count", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk("single_rx_word", 32'(rx_q[0]), 32'hA);

      // Round robin with all four held valid.
      do_reset();
      @(posedge clk); #1;
      valid = 4'b1111;
      src_data = 16'h4321;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         @(negedge clk);
         while (ready == 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("rr%0d_ready", k), 32'(ready), 32'(1) << (k % 4));
         chk($sformatf("rr%0d_not_busy", k), 32'(busy), 32'd0);
         @(posedge clk); #1;
         if (k == 4) valid = '0;
         @(negedge clk);
         chk($sformatf("rr%0d_gid", k), 32'(gid), 32'(k % 4));
      end
      wait_idle("rr_idle");
      chk("rr_rx_count", 32'(rx_q.size()), 32'd5);
      for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
         chk($sformatf("rr_rx%0d", k), 32'(rx_q[k]), 32'((k % 4) + 1));
      end

      // Backpressure: source 1 arrives while source 0 is in flight.
      do_reset();
      @(posedge clk); #1;
      valid = 4'b0001;
      src_data = 16'h0065;
      @(negedge clk);
      chk("bp_ready0", 32'(ready), 32'b0001);
      @(posedge clk); #1;
      valid = 4'b0010;
      n = 0;
      bad_ready = 0;
      bad_data = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         if (ready != 4'b0000) bad_ready++;
         if (data != 4'h5) bad_data++;
         @(negedge clk);
         n++;
      end
      chk("bp_was_busy", 32'(n > 2), 32'd1);
      chk("bp_busy_ends", 32'(busy), 32'd0);
      chk("bp_ready_while_busy", 32'(bad_ready), 32'd0);
      chk("bp_data_changed", 32'(bad_data), 32'd0);
      chk("bp_ready1", 32'(ready), 32'b0010);
      @(posedge clk); #1;
      valid = '0;
      wait_idle("bp_idle");
      chk("bp_rx_count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() > 1) begin
         chk("bp_rx0", 32'(rx_q[0]), 32'h5);
         chk("bp_rx1", 32'(rx_q[1]), 32'h6);
      end

      // Reset in the middle of a request.
      do_reset();
      @(posedge clk); #1;
      valid = 4'b0100;
      src_data = 16'h0300;
      @(posedge clk); #1;
      valid = '0;
      @(negedge clk);
      chk("mid_req_before", 32'(req), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      valid = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      chk("mid_req_dropped", 32'(req), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_ready_in_reset", 32'(ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      valid = '0;
      rst_n = 1'b1;
      rx_q.delete();
      @(posedge clk); #1;
      valid = 4'b1001;
      src_data = 16'h9007;
      @(negedge clk);
      chk("mid_ptr_reset_ready", 32'(ready), 32'b0001);
      @(posedge clk); #1;
      valid = '0;
      wait_idle("mid_idle0");
      @(posedge clk); #1;
      valid = 4'b1000;
      @(negedge clk);
      chk("mid_ready3", 32'(ready), 32'b1000);
      @(posedge clk); #1;
      valid = '0;
      @(negedge clk);
      chk("mid_gid3", 32'(gid), 32'd3);
      chk("mid_data3", 32'(data), 32'h9);
      wait_idle("mid_idle1");
      chk("mid_rx_count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() > 1) begin
         chk("mid_rx0", 32'(rx_q[0]), 32'h7);
         chk("mid_rx1", 32'(rx_q[1]), 32'h9);
      end

      // Ack held low.
      do_reset();
      ack_block = 1'b1;
      @(posedge clk); #1;
      valid = 4'b0001;
      src_data = 16'h000B;
      @(posedge clk); #1;
      valid = '0;
      n = 0;
      saw_tmo = 0;
      @(negedge clk);
      while (req && n < 40) begin
         if (tmo) saw_tmo++;
         @(negedge clk);
         n++;
      end
      chk("to_early_pulse", 32'(saw_tmo), 32'd0);
`ifdef CDC_HS_TIMEOUT_EN
      chk("to_req_high_cycles", 32'(n), 32'(TO));
      chk("to_pulse", 32'(tmo), 32'd1);
      chk("to_wait_lo_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("to_pulse_clear", 32'(tmo), 32'd0);
      chk("to_idle", 32'(busy), 32'd0);
`else
      chk("noto_req_stuck", 32'(req), 32'd1);
      chk("noto_cycles", 32'(n), 32'd40);
      chk("noto_timeout_low", 32'(tmo), 32'd0);
`endif
      do_reset();
      ack_block = 1'b0;

      // Randomized traffic against the round-robin reference model.
      do_reset();
      m_ptr = 0;
      pending = 1'b0;
      m_word = '0;
      m_g = 0;
      exp_q.delete();
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk); #1;
         valid = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) valid = '0;
         src_data = 16'($urandom);
         @(negedge clk);
         if (pending) begin
            chk("rnd_req", 32'(req), 32'd1);
            chk("rnd_data", 32'(data), 32'(m_word));
            chk("rnd_gid", 32'(gid), 32'(m_g));
            pending = 1'b0;
         end else if (req) begin
            chk("rnd_data_hold", 32'(data), 32'(m_word));
         end
         g = rr_pick(valid, m_ptr);
         if (busy) begin
            chk("rnd_ready_busy", 32'(ready), 32'd0);
         end else begin
            chk("rnd_ready", 32'(ready), (g < 0) ? 32'd0 : (32'(1) << g));
            if (g >= 0) begin
               m_word = src_data[g*4 +: 4];
               m_g = g;
               m_ptr = (g + 1) % N;
               exp_q.push_back(m_word);
               pending = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      valid = '0;
      wait_idle("rnd_idle");
      chk("rnd_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
         chk($sformatf("rnd_rx%0d", k), 32'(rx_q[k]), 32'(exp_q[k]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
